mcu_multichannel: RTL and testbench
===================================

# mcu_multichannel

Parametrised main control unit for the AES datapath. It serves `NUM_CH` independent receive/transmit FIFO pairs instead of a single pair, and keeps a separate encrypt/decrypt mode per channel. It sequences key generation, round-robin arbitration between ready channels, the dequeue → AES load → result enqueue handshake, and deferred key reloads. It sits between the per-channel Rx/Tx FIFOs, the key generator and the AES core.

## Interface
Parameters:
- `NUM_CH`, default 2: number of FIFO channel pairs, 1..8.
- `CH_W`, default `$clog2(NUM_CH)` (min 1): channel index width.
- `CNT_W`, default 16: width of the completed-block counter.

Ports:
- `clk` in 1: system clock. One clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `key_in` in 1: key reload request pulse.
- `generation_done` in 1: key generator finished (level).
- `enc_pulse` in NUM_CH: per-channel request to switch to encrypt mode.
- `dec_pulse` in NUM_CH: per-channel request to switch to decrypt mode.
- `emptyRx` in NUM_CH: Rx FIFO i empty.
- `fullRx` in NUM_CH: Rx FIFO i full.
- `fullTx` in NUM_CH: Tx FIFO i full.
- `accepted` in 1: AES core has taken the block (level).
- `data_done` in 1: AES result valid (level).
- `mcu_key_in` out 1: one-cycle start pulse to the key generator.
- `rcv_deq` out NUM_CH: one-hot, one-cycle dequeue pulse.
- `read_fifo` out 1: one-cycle AES load strobe.
- `trans_enq` out NUM_CH: one-hot, one-cycle enqueue pulse.
- `is_encrypt` out 1: mode of the block in flight.
- `ch_sel` out CH_W: channel in flight; steers the FIFO data muxes.
- `status_bits` out 4: `{key_valid, state[2:0]}`.
- `block_cnt` out CNT_W: completed blocks, wraps to 0.
- `rx_overflow` out NUM_CH: sticky; set when `fullRx[i]` is high in NOKEY or KEYWAIT state.

## Operation
- State codes: NOKEY=0, KEYWAIT=1, READY=2, DEQ=3, LOAD=4, BUSY=5, ENQ=6.
- **NOKEY:** on `key_in`, pulse `mcu_key_in` for 1 cycle and go to KEYWAIT.
- **KEYWAIT:** stay until `generation_done`; then set `key_valid` and go to READY. `key_in` here is ignored.
- **READY:** a channel is eligible when `!emptyRx[i] && !fullTx[i]`.
  - Round-robin grant: search starts at `last+1` mod `NUM_CH`.
  - Next cycle: DEQ, with `ch_sel` = granted channel and `is_encrypt` = mode[granted channel].
  - No eligible channel: stay in READY.
- **DEQ:** `rcv_deq[ch_sel]` and `read_fifo` both high for exactly 1 cycle, then LOAD.
- **LOAD:** wait for `accepted`, then BUSY.
- **BUSY:** wait for `data_done`, then ENQ.
- **ENQ:**
  - If `fullTx[ch_sel]`: stall with `trans_enq` low.
  - Else: pulse `trans_enq[ch_sel]`, increment `block_cnt` (wraps at all-ones), set `last = ch_sel`.
  - Then go to READY, or to NOKEY-reload (below) if a key reload is pending.
- **Key reload while `key_valid`:**
  - In READY: a `key_in` pulse triggers the reload immediately.
  - In DEQ/LOAD/BUSY/ENQ: `key_in` sets `key_pend`.
  - On leaving ENQ with `key_pend` set: clear `key_valid` and `key_pend`, pulse `mcu_key_in`, go to KEYWAIT.
- **Mode registers:**
  - Reset value is all 1 (encrypt).
  - `enc_pulse[i]` sets mode[i]; `dec_pulse[i]` clears it.
  - Both high in the same cycle: no change.
  - Updates apply at any time. `is_encrypt` is captured at grant, so it is stable for the whole block.
- **`rx_overflow[i]`:** cleared only by reset.

## Timing
- Reset values:
  - State NOKEY, `key_valid` 0, `key_pend` 0, `last` = `NUM_CH-1` (so channel 0 is searched first).
  - All pulse outputs 0, `ch_sel` 0, `is_encrypt` 1, `block_cnt` 0, `rx_overflow` 0, `status_bits` = 4'b0000.
- All outputs are registered. Reset mid-block abandons the block: no enqueue, and the key is lost.
- `key_in` high in cycle t: `mcu_key_in` high in cycle t+1.
- Minimum block latency:
  - With `accepted` and `data_done` both already high, READY→DEQ→LOAD→BUSY→ENQ takes 5 cycles from grant.
  - `trans_enq` fires 4 cycles after `rcv_deq`.
- `accepted` or `data_done` seen in the same cycle a state is entered: advance on the next edge. No state is skipped.
- `status_bits` reflects the current state register.

## Test plan
- **Reset + key load:** reset, pulse `key_in` → `mcu_key_in` 1 cycle later, `status_bits`=4'b0001. Raise `generation_done` → `status_bits`=4'b1010.
- **Single block, NUM_CH=2:**
  - Stimulus: `emptyRx`=2'b10; `accepted` and `data_done` tied high.
  - Required: `rcv_deq`=2'b01 + `read_fifo`; 4 cycles later `trans_enq`=2'b01; `block_cnt`=1; `is_encrypt`=1.
- **Round robin:** both Rx non-empty for 4 blocks → grant order 0,1,0,1; `block_cnt`=4.
- **Tx backpressure + mode:**
  - `dec_pulse[1]` then `enc_pulse[1]`+`dec_pulse[1]` together → mode[1] stays 0.
  - Block on channel 1 runs with `is_encrypt`=0.
  - Hold `fullTx[1]`=1 in ENQ for 3 cycles → no `trans_enq`; release → `trans_enq`=2'b10.
- **Deferred key:** `key_in` during BUSY → block completes and enqueues, then `mcu_key_in` pulses, `status_bits`=4'b0001, no new grant until `generation_done`.
- **Reset mid-LOAD + overflow:**
  - Reset mid-LOAD → all outputs return to reset values, `block_cnt`=0.
  - Then with `fullRx`=2'b01 in NOKEY → `rx_overflow`=2'b01, which stays set after the key loads.

Source files
------------

// File: rtl/mcu_multichannel.sv
// mcu_multichannel: AES control unit that round-robins NUM_CH Rx/Tx FIFO pairs,
// keeps a per-channel encrypt/decrypt mode and defers key reloads until the block in flight is done.
module mcu_multichannel #(
  parameter int NUM_CH = 2,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              key_in,
  input  logic              generation_done,
  input  logic [NUM_CH-1:0] enc_pulse,
  input  logic [NUM_CH-1:0] dec_pulse,
  input  logic [NUM_CH-1:0] emptyRx,
  input  logic [NUM_CH-1:0] fullRx,
  input  logic [NUM_CH-1:0] fullTx,
  input  logic              accepted,
  input  logic              data_done,
  output logic              mcu_key_in,
  output logic [NUM_CH-1:0] rcv_deq,
  output logic              read_fifo,
  output logic [NUM_CH-1:0] trans_enq,
  output logic              is_encrypt,
  output logic [CH_W-1:0]   ch_sel,
  output logic [3:0]        status_bits,
  output logic [CNT_W-1:0]  block_cnt,
  output logic [NUM_CH-1:0] rx_overflow
);
  typedef enum logic [2:0] {
    NOKEY = 3'd0, KEYWAIT = 3'd1, READY = 3'd2, DEQ = 3'd3,
    LOAD = 3'd4, BUSY = 3'd5, ENQ = 3'd6
  } state_t;
  state_t state, state_n;
  logic key_valid, key_pend, do_key, do_grant, do_enq, set_valid, found, in_block, pre_key;
  logic [CH_W-1:0] last, gnt, idx;
  logic [NUM_CH-1:0] mode;
  assign status_bits = {key_valid, state};
  assign in_block = state inside {DEQ, LOAD, BUSY, ENQ};
  assign pre_key = state inside {NOKEY, KEYWAIT};
  // Round-robin search starting just after the last channel served
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last) + i) % NUM_CH);
      if (!found && !emptyRx[idx] && !fullTx[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    do_key = 1'b0;
    do_grant = 1'b0;
    do_enq = 1'b0;
    set_valid = 1'b0;
    case (state)
      NOKEY: begin
        do_key = key_in;
        state_n = key_in ? KEYWAIT : NOKEY;
      end
      KEYWAIT: begin
        set_valid = generation_done;
        state_n = generation_done ? READY : KEYWAIT;
      end
      READY: begin
        do_key = key_in;
        do_grant = !key_in && found;
        state_n = key_in ? KEYWAIT : (found ? DEQ : READY);
      end
      DEQ: state_n = LOAD;
      LOAD: state_n = accepted ? BUSY : LOAD;
      BUSY: state_n = data_done ? ENQ : BUSY;
      ENQ: begin
        do_enq = !fullTx[ch_sel];
        do_key = do_enq && (key_pend || key_in);
        state_n = !do_enq ? ENQ : (do_key ? KEYWAIT : READY);
      end
      default: state_n = NOKEY;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) state <= NOKEY;
    else state <= state_n;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      key_valid <= 1'b0;
      key_pend <= 1'b0;
      last <= CH_W'(NUM_CH - 1);
      mode <= '1;
      mcu_key_in <= 1'b0;
      rcv_deq <= '0;
      read_fifo <= 1'b0;
      trans_enq <= '0;
      is_encrypt <= 1'b1;
      ch_sel <= '0;
      block_cnt <= '0;
      rx_overflow <= '0;
    end else begin
      key_valid <= do_key ? 1'b0 : (set_valid | key_valid);
      key_pend <= do_key ? 1'b0 : (key_pend | (key_in & in_block));
      last <= do_enq ? ch_sel : last;
      // Simultaneous enc and dec pulses leave the mode untouched
      mode <= (mode & ~(dec_pulse & ~enc_pulse)) | (enc_pulse & ~dec_pulse);
      mcu_key_in <= do_key;
      rcv_deq <= do_grant ? NUM_CH'(1) << gnt : '0;
      read_fifo <= do_grant;
      trans_enq <= do_enq ? NUM_CH'(1) << ch_sel : '0;
      is_encrypt <= do_grant ? mode[gnt] : is_encrypt;
      ch_sel <= do_grant ? gnt : ch_sel;
      block_cnt <= block_cnt + CNT_W'(do_enq);
      rx_overflow <= rx_overflow | ({NUM_CH{pre_key}} & fullRx);
    end
endmodule

// File: tb/tb_mcu_multichannel.sv
// tb_mcu_multichannel: directed bench for mcu_multichannel (NUM_CH=2) with a grant scoreboard.
module tb_mcu_multichannel;
  localparam int N = 2;
  logic clk = 1'b0, n_reset = 1'b1, key_in = 1'b0, generation_done = 1'b0;
  logic accepted = 1'b0, data_done = 1'b0;
  logic [N-1:0] enc_pulse = '0, dec_pulse = '0, emptyRx = '1, fullRx = '0, fullTx = '0;
  logic mcu_key_in, read_fifo, is_encrypt;
  logic [N-1:0] rcv_deq, trans_enq, rx_overflow;
  logic [0:0] ch_sel;
  logic [3:0] status_bits;
  logic [15:0] block_cnt;
  typedef struct packed { logic ch; logic enc; } exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mcu_multichannel #(.NUM_CH(N)) dut (
    .clk(clk), .n_reset(n_reset), .key_in(key_in), .generation_done(generation_done),
    .enc_pulse(enc_pulse), .dec_pulse(dec_pulse), .emptyRx(emptyRx), .fullRx(fullRx),
    .fullTx(fullTx), .accepted(accepted), .data_done(data_done), .mcu_key_in(mcu_key_in),
    .rcv_deq(rcv_deq), .read_fifo(read_fifo), .trans_enq(trans_enq), .is_encrypt(is_encrypt),
    .ch_sel(ch_sel), .status_bits(status_bits), .block_cnt(block_cnt), .rx_overflow(rx_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    n_reset = 1'b0;
    #1;
    chk("rst_status", status_bits, 4'b0000);
    chk("rst_block_cnt", block_cnt, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_is_encrypt", is_encrypt, 1);
    chk("rst_rx_overflow", rx_overflow, 0);
    chk("rst_pulses", {mcu_key_in, read_fifo, rcv_deq, trans_enq}, 0);
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic key_load();
    key_in = 1'b1; tick(); key_in = 1'b0;
    chk("mcu_key_in_pulse", mcu_key_in, 1);
    chk("status_keywait", status_bits, 4'b0001);
    key_in = 1'b1; tick(); key_in = 1'b0;
    chk("key_in_ignored_keywait", mcu_key_in, 0);
    chk("status_still_keywait", status_bits, 4'b0001);
    generation_done = 1'b1; tick(); generation_done = 1'b0;
    chk("status_ready", status_bits, 4'b1010);
  endtask

  task automatic wait_deq(input bit stop);
    int n = 0;
    while (rcv_deq == '0 && n < 30) begin tick(); n++; end
    chk("deq_seen", rcv_deq != '0, 1);
    chk("sb_has_entry", sb.size() != 0, 1);
    cur = '0;
    if (sb.size() != 0) cur = sb.pop_front();
    chk("rcv_deq", rcv_deq, 2'b01 << cur.ch);
    chk("read_fifo", read_fifo, 1);
    chk("ch_sel", ch_sel, cur.ch);
    chk("is_encrypt", is_encrypt, cur.enc);
    if (stop) emptyRx = '1;
  endtask

  task automatic finish_blk(input int stall, input bit kbusy);
    int lat = 0;
    if (kbusy) begin
      repeat (2) begin tick(); lat++; end
      chk("status_busy", status_bits, 4'b1101);
      key_in = 1'b1; tick(); lat++; key_in = 1'b0;
    end
    if (stall > 0) begin
      fullTx = '1;
      while (status_bits[2:0] != 3'd6 && lat < 30) begin tick(); lat++; end
      chk("status_enq", status_bits, 4'b1110);
      repeat (stall) begin
        chk("stall_no_enq", trans_enq, 0);
        tick(); lat++;
      end
      fullTx = '0;
    end
    while (trans_enq == '0 && lat < 30) begin tick(); lat++; end
    chk("trans_enq", trans_enq, 2'b01 << cur.ch);
    chk("latency", lat, 4 + stall);
  endtask

  initial begin
    #2;
    reset_dut();
    key_load();
    // single block on channel 0
    accepted = 1'b1; data_done = 1'b1; emptyRx = 2'b10;
    sb.push_back('{ch: 1'b0, enc: 1'b1});
    wait_deq(1); finish_blk(0, 0);
    chk("block_cnt_single", block_cnt, 1);
    // round robin from a fresh reset
    reset_dut();
    key_load();
    emptyRx = 2'b00;
    for (int i = 0; i < 4; i++) sb.push_back('{ch: 1'(i % 2), enc: 1'b1});
    for (int i = 0; i < 4; i++) begin wait_deq(i == 3); finish_blk(0, 0); end
    chk("block_cnt_rr", block_cnt, 4);
    // mode change and Tx backpressure on channel 1
    dec_pulse = 2'b10; tick(); dec_pulse = 2'b00;
    enc_pulse = 2'b10; dec_pulse = 2'b10; tick(); enc_pulse = 2'b00; dec_pulse = 2'b00;
    emptyRx = 2'b01;
    sb.push_back('{ch: 1'b1, enc: 1'b0});
    wait_deq(1); finish_blk(3, 0);
    chk("block_cnt_bp", block_cnt, 5);
    // deferred key reload requested during BUSY
    emptyRx = 2'b10;
    sb.push_back('{ch: 1'b0, enc: 1'b1});
    wait_deq(1); finish_blk(0, 1);
    chk("deferred_mcu_key_in", mcu_key_in, 1);
    chk("deferred_status", status_bits, 4'b0001);
    chk("block_cnt_deferred", block_cnt, 6);
    emptyRx = 2'b10;
    repeat (4) begin tick(); chk("no_grant_keywait", rcv_deq, 0); end
    generation_done = 1'b1; tick(); generation_done = 1'b0;
    chk("status_ready_reload", status_bits, 4'b1010);
    sb.push_back('{ch: 1'b0, enc: 1'b1});
    wait_deq(1); finish_blk(0, 0);
    chk("block_cnt_after_reload", block_cnt, 7);
    // reset while waiting in LOAD, then overflow before the key loads
    accepted = 1'b0; emptyRx = 2'b01;
    sb.push_back('{ch: 1'b1, enc: 1'b0});
    wait_deq(1); tick();
    chk("status_load", status_bits, 4'b1100);
    reset_dut();
    fullRx = 2'b01; tick(); fullRx = 2'b00;
    chk("rx_overflow_set", rx_overflow, 2'b01);
    key_load();
    chk("rx_overflow_sticky", rx_overflow, 2'b01);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
